rv_inst_encoder: RTL and testbench
==================================

# rv_inst_encoder

Instruction encoder: the inverse of the instruction decoder. It accepts symbolic instructions (operation select, register numbers, signed immediate) over a valid/ready handshake and range-checks the immediate. It packs each instruction into its RV64 32-bit word, expands the LI pseudo-instruction into LUI+ADDIW, and buffers the words in an output FIFO. It sits between the test-program generator and instruction memory preload, and produces programs that the decoder disassembles back.

## Interface
- FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready at clk edge
- in_op  in  6  operation select:
  - 0–8: ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI
  - 9–18: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND
  - 19–26: MUL MULH MULHSU MULHU DIV DIVU REM REMU
  - 27 LUI, 28 AUIPC, 29 LD, 30 SD, 31 BEQ, 32 BNE, 33 JAL, 34 JALR, 35 LI, 36 NOP
  - 37–63: undefined
- in_rd, in_rs1, in_rs2  in  5 each  register numbers
- in_imm  in  32  signed immediate; for LUI/AUIPC it is the raw 20-bit field
- out_valid  out  1  FIFO head valid
- out_ready  in  1  pop when out_valid && out_ready
- out_inst  out  32  encoded word at FIFO head
- out_err  out  1  head word is a substituted NOP caused by an error
- out_count  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy

## Operation
- Per-format field packing (standard RV64):
  - R: funct7|rs2|rs1|f3|rd|0x33; funct7 is 0x20 for SUB/SRA, 0x01 for M ops, else 0x00.
  - I-ALU: opcode 0x13. Shifts use a 6-bit shamt; SRAI sets bit 30.
  - LD: 0x03 f3=011. SD: 0x23 f3=011. BEQ/BNE: 0x63 f3=000/001. JAL: 0x6F. JALR: 0x67 f3=000. LUI: 0x37. AUIPC: 0x17. NOP = 0x00000013.
- Immediate checks:
  - I/S: in_imm ∈ [−2048, 2047].
  - Shifts: [0, 63].
  - B: [−4096, 4094], even.
  - J: [−2^20, 2^20−2], even.
  - LUI/AUIPC: in_imm[31:12]==0.
- Any failed check, or an undefined in_op, emits 0x00000013 with err=1. Unused register fields are ignored.
- LI:
  - If in_imm ∈ [−2048, 2047]: one word, ADDI rd,x0,imm.
  - Otherwise two words: LUI rd,((in_imm+0x800)>>12)[19:0], then ADDIW rd,rd,in_imm[11:0] (opcode 0x1B).
- FIFO entries are 33 bits {err, inst}. Order is strictly preserved.
- State machine:
  - IDLE: accept a request. An LI needing two words writes the LUI word and moves to EXPAND.
  - EXPAND: in_ready=0. Write the ADDIW word when the FIFO is not full, then return to IDLE.

## Timing
- Reset values: in_ready=0 while reset is asserted, out_valid=0, out_inst=0, out_err=0, out_count=0, state=IDLE. Reset takes effect immediately (asynchronous) and clears the FIFO and any pending EXPAND.
- in_ready = (state==IDLE) && (out_count<FIFO_DEPTH). It is computed from registered state only. There is no full-bypass on a simultaneous pop.
- Latency: a request accepted at edge N with the FIFO empty appears at the head with out_valid=1 after edge N (visible in cycle N+1).
- LI expansion: the LUI word is written at edge N and the ADDIW word at edge N+1 if not full. If full, ADDIW waits in EXPAND until a pop frees a slot.
- Simultaneous push and pop: occupancy is unchanged and both take effect.
- Outputs are held stable while out_valid && !out_ready.
- Pointers wrap modulo FIFO_DEPTH.

## Configuration
- RV_M_EXT_EN defined: ops 19–26 encode as RV64M, funct7=0x01, f3 = op−19.
- RV_M_EXT_EN undefined: ops 19–26 are treated as undefined and emit NOP with err=1. No M-extension logic is synthesized.

## Test plan
- ADDI rd=10, rs1=0, imm=5 → out_inst 0x00500513, out_err=0, out_valid one cycle after acceptance.
- ADD rd=3, rs1=1, rs2=2 → 0x002081B3. MUL rd=5, rs1=6, rs2=7 → 0x027302B3 with RV_M_EXT_EN defined; 0x00000013 with out_err=1 when undefined.
- LI rd=10, imm=0x12345678 → 0x12345537 then 0x6785051B. in_ready is low for exactly one cycle. LI imm=−1 → single word 0xFFF00513.
- ADDI imm=2048, then BEQ imm=3, then in_op=40 → three words, each 0x00000013 with out_err=1.
- Hold out_ready=0 and push 4 ADDIs → in_ready=0 with out_count=4. Issue LI 0x12345678 after 3 pushes → LUI is written, ADDIW is held in EXPAND, and ADDIW is written the edge after the first pop.
- Assert reset while in EXPAND with 2 words queued → out_valid=0 and out_count=0 immediately. After release, the next request encodes normally.

Source files
------------

// File: rtl/rv_inst_encoder.sv
// RV64 instruction encoder: symbolic request -> 32-bit word, LI expansion, output FIFO.
// Optional M-extension encoding (ops 19-26) is enabled by defining RV_M_EXT_EN.
module rv_inst_encoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [5:0]                          in_op,
    input  logic [4:0]                          in_rd,
    input  logic [4:0]                          in_rs1,
    input  logic [4:0]                          in_rs2,
    input  logic [31:0]                         in_imm,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [31:0]                         out_inst,
    output logic                                out_err,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     out_count
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [31:0]   NOP_WORD = 32'h0000_0013;
    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);

    typedef enum logic {S_IDLE, S_EXPAND} state_t;

    state_t        r_state, w_nextState;
    logic [32:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wrPtr, r_rdPtr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_pendWord;

    logic signed [31:0] w_imm;
    logic        w_fitsI, w_fitsShamt, w_fitsB, w_fitsJ, w_fitsU;
    logic [19:0] w_luiImm;
    logic [31:0] w_word, w_addiwWord;
    logic [2:0]  w_f3;
    logic        w_ok, w_err, w_li2;
    logic        w_notFull, w_accept, w_push, w_pop;
    logic [32:0] w_pushData;

    // funct3 shared by the I-ALU, shift and R-type groups
    function automatic logic [2:0] f3Of(input logic [5:0] op);
        case (op)
            6'd1, 6'd12:        f3Of = 3'b010;
            6'd2, 6'd13:        f3Of = 3'b011;
            6'd3, 6'd14:        f3Of = 3'b100;
            6'd4, 6'd17:        f3Of = 3'b110;
            6'd5, 6'd18:        f3Of = 3'b111;
            6'd6, 6'd11:        f3Of = 3'b001;
            6'd7, 6'd8, 6'd15, 6'd16: f3Of = 3'b101;
            default:            f3Of = 3'b000;
        endcase
    endfunction

    assign w_imm       = in_imm;
    assign w_fitsI     = (w_imm >= -32'sd2048) && (w_imm <= 32'sd2047);
    assign w_fitsShamt = (in_imm[31:6] == '0);
    assign w_fitsB     = (w_imm >= -32'sd4096) && (w_imm <= 32'sd4094) && !in_imm[0];
    assign w_fitsJ     = (w_imm >= -32'sd1048576) && (w_imm <= 32'sd1048574) && !in_imm[0];
    assign w_fitsU     = (in_imm[31:12] == '0);
    // Rounding by 0x800 compensates for ADDIW sign-extending its low 12 bits
    assign w_luiImm    = 20'((in_imm + 32'h800) >> 12);
    assign w_addiwWord = {in_imm[11:0], in_rd, 3'b000, in_rd, 7'h1B};
    assign w_f3        = f3Of(in_op);

    always_comb begin
        w_word = NOP_WORD;
        w_ok   = 1'b1;
        w_li2  = 1'b0;
        case (in_op)
            6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5: begin
                w_ok   = w_fitsI;
                w_word = {in_imm[11:0], in_rs1, w_f3, in_rd, 7'h13};
            end
            6'd6, 6'd7, 6'd8: begin
                w_ok   = w_fitsShamt;
                w_word = {(in_op == 6'd8) ? 6'b010000 : 6'b000000, in_imm[5:0],
                          in_rs1, w_f3, in_rd, 7'h13};
            end
            6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17, 6'd18:
                w_word = {(in_op == 6'd10 || in_op == 6'd16) ? 7'h20 : 7'h00,
                          in_rs2, in_rs1, w_f3, in_rd, 7'h33};
`ifdef RV_M_EXT_EN
            6'd19, 6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25, 6'd26:
                w_word = {7'h01, in_rs2, in_rs1, 3'(in_op - 6'd19), in_rd, 7'h33};
`endif
            6'd27: begin
                w_ok   = w_fitsU;
                w_word = {in_imm[19:0], in_rd, 7'h37};
            end
            6'd28: begin
                w_ok   = w_fitsU;
                w_word = {in_imm[19:0], in_rd, 7'h17};
            end
            6'd29: begin
                w_ok   = w_fitsI;
                w_word = {in_imm[11:0], in_rs1, 3'b011, in_rd, 7'h03};
            end
            6'd30: begin
                w_ok   = w_fitsI;
                w_word = {in_imm[11:5], in_rs2, in_rs1, 3'b011, in_imm[4:0], 7'h23};
            end
            6'd31, 6'd32: begin
                w_ok   = w_fitsB;
                w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 2'b00, ~in_op[0],
                          in_imm[4:1], in_imm[11], 7'h63};
            end
            6'd33: begin
                w_ok   = w_fitsJ;
                w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'h6F};
            end
            6'd34: begin
                w_ok   = w_fitsI;
                w_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'h67};
            end
            6'd35: begin
                if (w_fitsI) begin
                    w_word = {in_imm[11:0], 5'd0, 3'b000, in_rd, 7'h13};
                end else begin
                    w_word = {w_luiImm, in_rd, 7'h37};
                    w_li2  = 1'b1;
                end
            end
            6'd36:   w_word = NOP_WORD;
            default: w_ok   = 1'b0;
        endcase
        if (!w_ok) w_word = NOP_WORD;
    end

    assign w_err     = !w_ok;
    assign w_notFull = (r_count < FULL);
    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:   if (w_accept && w_li2) w_nextState = S_EXPAND;
            S_EXPAND: if (w_notFull)         w_nextState = S_IDLE;
            default:  w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        w_push     = 1'b0;
        w_pushData = {w_err, w_word};
        case (r_state)
            S_IDLE: begin
                in_ready = !reset && w_notFull;
                w_push   = in_valid && !reset && w_notFull;
            end
            S_EXPAND: begin
                w_push     = w_notFull;
                w_pushData = {1'b0, r_pendWord};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  r_pendWord <= '0;
        else if (w_accept && w_li2) r_pendWord <= w_addiwWord;
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= w_pushData;
                r_wrPtr        <= r_wrPtr + PW'(1);
            end
            if (w_pop) r_rdPtr <= r_rdPtr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign out_valid = (r_count != '0);
    assign out_count = r_count;
    assign out_inst  = out_valid ? r_mem[r_rdPtr][31:0] : '0;
    assign out_err   = out_valid ? r_mem[r_rdPtr][32]   : 1'b0;

endmodule

// File: tb/tb_rv_inst_encoder.sv
// Self-checking bench for rv_inst_encoder: directed literal cases plus randomized
// traffic against a queue-based reference model of the encoder and FIFO.
module tb_rv_inst_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_op = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic        out_err;
    logic [$clog2(DEPTH+1)-1:0] out_count;

    int nChecks = 0;
    int nFails  = 0;

    bit [32:0] mq[$];
    bit        mExp = 1'b0;
    bit [32:0] mPend = '0;

    always #5 clk = ~clk;

    rv_inst_encoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_err(out_err), .out_count(out_count)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding computed from field positions with plain arithmetic
    function automatic void refEncode(input int op, input int unsigned rd, input int unsigned rs1,
                                      input int unsigned rs2, input longint imm,
                                      output int n, output bit [32:0] w0, output bit [32:0] w1);
        int unsigned u, f3;
        int unsigned iAluF3[6] = '{0, 2, 3, 4, 6, 7};
        int unsigned rF3[10]   = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
        bit ok;
        bit [31:0] word;
        u = imm[31:0];
        n = 1; w1 = '0; ok = 1'b1; word = 32'h13;
        if (op <= 5) begin
            ok = (imm >= -2048) && (imm <= 2047);
            word = ((u & 'hFFF) << 20) | (rs1 << 15) | (iAluF3[op] << 12) | (rd << 7) | 'h13;
        end else if (op <= 8) begin
            ok = (imm >= 0) && (imm <= 63);
            f3 = (op == 6) ? 1 : 5;
            word = (u << 20) | ((op == 8) ? (1 << 30) : 0) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 'h13;
        end else if (op <= 18) begin
            word = (((op == 10 || op == 16) ? 'h20 : 0) << 25) | (rs2 << 20) | (rs1 << 15)
                 | (rF3[op-9] << 12) | (rd << 7) | 'h33;
        end else if (op <= 26) begin
`ifdef RV_M_EXT_EN
            word = (1 << 25) | (rs2 << 20) | (rs1 << 15) | ((op - 19) << 12) | (rd << 7) | 'h33;
`else
            ok = 1'b0;
`endif
        end else begin
            case (op)
                27, 28: begin
                    ok = (u >> 12) == 0;
                    word = (u << 12) | (rd << 7) | ((op == 27) ? 'h37 : 'h17);
                end
                29: begin
                    ok = (imm >= -2048) && (imm <= 2047);
                    word = ((u & 'hFFF) << 20) | (rs1 << 15) | (3 << 12) | (rd << 7) | 'h03;
                end
                30: begin
                    ok = (imm >= -2048) && (imm <= 2047);
                    word = (((u >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (3 << 12)
                         | ((u & 31) << 7) | 'h23;
                end
                31, 32: begin
                    ok = (imm >= -4096) && (imm <= 4094) && (imm % 2 == 0);
                    word = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (rs2 << 20) | (rs1 << 15)
                         | ((op - 31) << 12) | (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | 'h63;
                end
                33: begin
                    ok = (imm >= -1048576) && (imm <= 1048574) && (imm % 2 == 0);
                    word = (((u >> 20) & 1) << 31) | (((u >> 1) & 'h3FF) << 21) | (((u >> 11) & 1) << 20)
                         | (((u >> 12) & 'hFF) << 12) | (rd << 7) | 'h6F;
                end
                34: begin
                    ok = (imm >= -2048) && (imm <= 2047);
                    word = ((u & 'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 'h67;
                end
                35: begin
                    if (imm >= -2048 && imm <= 2047) begin
                        word = ((u & 'hFFF) << 20) | (rd << 7) | 'h13;
                    end else begin
                        n = 2;
                        word = 32'(((((imm + 2048) >>> 12) & 'hFFFFF) << 12) | (rd << 7) | 'h37);
                        w1 = {1'b0, 32'(((u & 'hFFF) << 20) | (rd << 15) | (rd << 7) | 'h1B)};
                    end
                end
                36:      word = 32'h13;
                default: ok = 1'b0;
            endcase
        end
        w0 = ok ? {1'b0, word} : {1'b1, 32'h13};
    endfunction

    function automatic bit mReady();
        return !mExp && (mq.size() < DEPTH);
    endfunction

    always @(posedge clk or posedge reset) begin : model
        int n, sz;
        bit [32:0] w0, w1;
        if (reset) begin
            mq.delete();
            mExp = 1'b0;
        end else begin
            sz = mq.size();
            if (sz != 0 && out_ready) void'(mq.pop_front());
            if (mExp) begin
                if (sz < DEPTH) begin
                    mq.push_back(mPend);
                    mExp = 1'b0;
                end
            end else if (in_valid && sz < DEPTH) begin
                refEncode(int'(in_op), in_rd, in_rs1, in_rs2, longint'($signed(in_imm)), n, w0, w1);
                mq.push_back(w0);
                if (n == 2) begin
                    mPend = w1;
                    mExp  = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            checkOutput("reset in_ready", in_ready, 0);
            checkOutput("reset out_valid", out_valid, 0);
            checkOutput("reset out_count", out_count, 0);
            checkOutput("reset out_word", {out_err, out_inst}, 0);
        end else begin
            checkOutput("in_ready", in_ready, mReady());
            checkOutput("out_valid", out_valid, mq.size() != 0);
            checkOutput("out_count", out_count, mq.size());
            if (mq.size() != 0) checkOutput("head word", {out_err, out_inst}, mq[0]);
        end
    end

    task automatic applyStimulus(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [31:0] imm);
        bit done = 1'b0;
        @(negedge clk); #1;
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            done = mReady();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            nChecks++; nFails++;
            $display("[TB] FAIL accept timeout: op %0d not accepted within 100 cycles", op);
        end
    endtask

    function automatic logic [31:0] pickImm();
        int edges[18] = '{-2048, -2049, 2047, 2048, 0, 63, 64, -1, -4096, 4094, 4096,
                          -4097, 1048574, 1048576, -1048576, -1048578, 4095, 'hFFFFF};
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 6000)) - 32'd3000;
            1:       return $urandom;
            2:       return 32'(edges[$urandom_range(0, 17)]);
            default: return 32'($urandom_range(0, 'hFFFFF));
        endcase
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;

        applyStimulus(6'd0, 5'd10, 5'd0, 5'd0, 32'd5);
        @(negedge clk);
        checkOutput("ADDI literal", {out_valid, out_err, out_inst}, {2'b10, 32'h00500513});

        applyStimulus(6'd9, 5'd3, 5'd1, 5'd2, 32'd0);
        @(negedge clk);
        checkOutput("ADD literal", {out_err, out_inst}, {1'b0, 32'h002081B3});

        applyStimulus(6'd19, 5'd5, 5'd6, 5'd7, 32'd0);
        @(negedge clk);
`ifdef RV_M_EXT_EN
        checkOutput("MUL literal", {out_err, out_inst}, {1'b0, 32'h027302B3});
`else
        checkOutput("MUL disabled", {out_err, out_inst}, {1'b1, 32'h00000013});
`endif

        applyStimulus(6'd35, 5'd10, 5'd0, 5'd0, 32'h12345678);
        @(negedge clk);
        checkOutput("LI LUI literal", {in_ready, out_err, out_inst}, {2'b00, 32'h12345537});
        @(negedge clk);
        checkOutput("LI ADDIW literal", {in_ready, out_err, out_inst}, {2'b10, 32'h6785051B});

        applyStimulus(6'd35, 5'd10, 5'd0, 5'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        checkOutput("LI -1 literal", {in_ready, out_count, out_inst}, {1'b1, 3'd1, 32'hFFF00513});

        @(negedge clk); #1 out_ready = 1'b0;
        applyStimulus(6'd0, 5'd1, 5'd1, 5'd0, 32'd2048);
        applyStimulus(6'd31, 5'd0, 5'd1, 5'd2, 32'd3);
        applyStimulus(6'd40, 5'd1, 5'd1, 5'd1, 32'd0);
        for (int k = 3; k > 0; k--) begin
            @(negedge clk);
            checkOutput("error NOP", {out_count, out_err, out_inst}, {3'(k), 1'b1, 32'h00000013});
            #1 out_ready = 1'b1;
        end
        @(negedge clk); #1 out_ready = 1'b0;

        for (int k = 0; k < 4; k++) applyStimulus(6'd0, 5'(k + 1), 5'd0, 5'd0, 32'(k));
        @(negedge clk);
        checkOutput("full in_ready/count", {in_ready, out_count}, {1'b0, 3'd4});
        #1 out_ready = 1'b1;
        repeat (6) @(negedge clk);
        #1 out_ready = 1'b0;

        for (int k = 0; k < 3; k++) applyStimulus(6'd0, 5'd2, 5'd0, 5'd0, 32'(k));
        applyStimulus(6'd35, 5'd10, 5'd0, 5'd0, 32'h12345678);
        repeat (2) begin
            @(negedge clk);
            checkOutput("EXPAND held", {in_ready, out_count}, {1'b0, 3'd4});
        end
        #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        checkOutput("after pop", out_count, 3'd3);
        @(negedge clk);
        checkOutput("ADDIW written", {in_ready, out_count}, {1'b0, 3'd4});
        #1 out_ready = 1'b1;
        repeat (8) @(negedge clk);

        #1 out_ready = 1'b0;
        applyStimulus(6'd0, 5'd4, 5'd0, 5'd0, 32'd1);
        applyStimulus(6'd35, 5'd10, 5'd0, 5'd0, 32'h12345678);
        #1 reset = 1'b1;
        #1 checkOutput("async reset", {out_valid, out_count}, {1'b0, 3'd0});
        @(negedge clk); #1 reset = 1'b0; out_ready = 1'b1;
        applyStimulus(6'd9, 5'd3, 5'd1, 5'd2, 32'd0);
        @(negedge clk);
        checkOutput("post-reset ADD", {out_valid, out_err, out_inst}, {2'b10, 32'h002081B3});

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            in_op     = 6'($urandom_range(0, 40));
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            in_imm    = pickImm();
            out_ready = ($urandom_range(0, 9) < 6);
        end
        @(negedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("final drain", {out_valid, out_count}, {1'b0, 3'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
